// File: rtl/cache_miss_arbiter.sv
// cache_miss_arbiter: shares one memory port between I-cache fills, D-cache
// fills and D-cache write-through stores, and drives the fetch/MEM stalls.
// A fill issues WORDS_PER_BLOCK back-to-back reads and retires words as valids
// return. Memory latency is absorbed by counting valids, not by counting cycles.
module cache_miss_arbiter #(
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 16,
   parameter int WORDS_PER_BLOCK = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_miss,
   input  logic [ADDR_WIDTH-1:0] icache_miss_addr,
   input  logic                  dcache_miss,
   input  logic [ADDR_WIDTH-1:0] dcache_miss_addr,
   input  logic                  dcache_wr_req,
   input  logic [ADDR_WIDTH-1:0] dcache_wr_addr,
   input  logic [DATA_WIDTH-1:0] dcache_wr_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_enable,
   output logic                  mem_wr,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_data_valid,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic                  icache_data_we,
   output logic                  dcache_data_we,
   output logic                  icache_tag_we,
   output logic                  dcache_tag_we,
   output logic                  if_stall,
   output logic                  mem_stall
);

   // Counters must be able to hold WORDS_PER_BLOCK itself ("all issued").
   localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);
   localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(WORDS_PER_BLOCK);
   localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] base, base_next;
   logic                  tgt, tgt_next;
   logic [CNT_W-1:0]      issue_cnt, issue_cnt_next;
   logic [CNT_W-1:0]      recv_cnt, recv_cnt_next;

   // State and fill bookkeeping registers; reset aborts any fill in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         tgt       <= 1'b0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         state     <= state_next;
         base      <= base_next;
         tgt       <= tgt_next;
         issue_cnt <= issue_cnt_next;
         recv_cnt  <= recv_cnt_next;
      end
   end

   // Arbitration in IDLE (D miss, then store, then I miss) and the fill engine.
   always_comb begin
      state_next     = state;
      base_next      = base;
      tgt_next       = tgt;
      issue_cnt_next = issue_cnt;
      recv_cnt_next  = recv_cnt;
      mem_addr       = '0;
      mem_data_in    = '0;
      mem_enable     = 1'b0;
      mem_wr         = 1'b0;
      fill_data      = '0;
      fill_addr      = '0;
      icache_data_we = 1'b0;
      dcache_data_we = 1'b0;
      icache_tag_we  = 1'b0;
      dcache_tag_we  = 1'b0;

      case (state)
         IDLE: begin
            if (dcache_miss) begin
               state_next = FILL;
               base_next  = dcache_miss_addr & ~OFFSET_MASK;
               tgt_next   = 1'b1;
            end else if (dcache_wr_req) begin
               mem_enable  = 1'b1;
               mem_wr      = 1'b1;
               mem_addr    = dcache_wr_addr;
               mem_data_in = dcache_wr_data;
            end else if (icache_miss) begin
               state_next = FILL;
               base_next  = icache_miss_addr & ~OFFSET_MASK;
               tgt_next   = 1'b0;
            end
         end

         FILL: begin
            if (issue_cnt < FULL_CNT) begin
               mem_enable     = 1'b1;
               mem_addr       = base + (ADDR_WIDTH'(issue_cnt) << 1);
               issue_cnt_next = issue_cnt + CNT_W'(1);
            end
            if (mem_data_valid && (recv_cnt < FULL_CNT)) begin
               fill_data      = mem_data_out;
               fill_addr      = base + (ADDR_WIDTH'(recv_cnt) << 1);
               icache_data_we = ~tgt;
               dcache_data_we = tgt;
               recv_cnt_next  = recv_cnt + CNT_W'(1);
               if (recv_cnt == LAST_WORD) begin
                  icache_tag_we  = ~tgt;
                  dcache_tag_we  = tgt;
                  state_next     = IDLE;
                  issue_cnt_next = '0;
                  recv_cnt_next  = '0;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign if_stall  = icache_miss | ((state == FILL) & ~tgt);
   assign mem_stall = dcache_miss | ((state == FILL) & tgt) | (dcache_wr_req & (state == FILL));

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// tb_cache_miss_arbiter: directed bench for cache_miss_arbiter with a
// fixed-latency memory responder whose read data is address ^ 16'h5A5A.
module tb_cache_miss_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int WPB = 8;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          icache_miss;
   logic [AW-1:0] icache_miss_addr;
   logic          dcache_miss;
   logic [AW-1:0] dcache_miss_addr;
   logic          dcache_wr_req;
   logic [AW-1:0] dcache_wr_addr;
   logic [DW-1:0] dcache_wr_data;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic          mem_enable;
   logic          mem_wr;
   logic [DW-1:0] mem_data_out;
   logic          mem_data_valid;
   logic [DW-1:0] fill_data;
   logic [AW-1:0] fill_addr;
   logic          icache_data_we;
   logic          dcache_data_we;
   logic          icache_tag_we;
   logic          dcache_tag_we;
   logic          if_stall;
   logic          mem_stall;

   int tests_run    = 0;
   int tests_failed = 0;

   cache_miss_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB)
   ) dut (
      .clk(clk), .rst(rst),
      .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
      .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
      .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
      .dcache_wr_data(dcache_wr_data),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .fill_data(fill_data), .fill_addr(fill_addr),
      .icache_data_we(icache_data_we), .dcache_data_we(dcache_data_we),
      .icache_tag_we(icache_tag_we), .dcache_tag_we(dcache_tag_we),
      .if_stall(if_stall), .mem_stall(mem_stall)
   );

   always #5 clk = ~clk;

   // Memory responder: a read requested in cycle n returns valid data in cycle n+LAT.
   logic          req_pipe  [0:LAT-1];
   logic [AW-1:0] addr_pipe [0:LAT-1];
   always @(negedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         req_pipe[i]  <= req_pipe[i-1];
         addr_pipe[i] <= addr_pipe[i-1];
      end
      req_pipe[0]    <= (mem_enable === 1'b1) && (mem_wr === 1'b0);
      addr_pipe[0]   <= mem_addr;
      mem_data_valid <= (req_pipe[LAT-1] === 1'b1);
      mem_data_out   <= (req_pipe[LAT-1] === 1'b1) ? (addr_pipe[LAT-1] ^ 16'h5A5A) : '0;
   end

   // One cycle: drive inputs just after the edge, return at the mid-cycle check point.
   task automatic applyStimulus(input logic r, input logic im, input logic [AW-1:0] ima,
                                input logic dm, input logic [AW-1:0] dma,
                                input logic wr, input logic [AW-1:0] wra, input logic [DW-1:0] wrd);
      @(posedge clk);
      #1;
      rst              = r;
      icache_miss      = im;
      icache_miss_addr = ima;
      dcache_miss      = dm;
      dcache_miss_addr = dma;
      dcache_wr_req    = wr;
      dcache_wr_addr   = wra;
      dcache_wr_data   = wrd;
      #6;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic checkCycle(input string tag, input logic en, input logic wr,
                             input logic [AW-1:0] maddr, input logic [DW-1:0] mdin,
                             input logic [DW-1:0] fdata, input logic [AW-1:0] faddr,
                             input logic idwe, input logic ddwe, input logic itwe, input logic dtwe,
                             input logic ifs, input logic ms);
      checkOutput({tag, " mem_enable"},     32'(mem_enable),     32'(en));
      checkOutput({tag, " mem_wr"},         32'(mem_wr),         32'(wr));
      checkOutput({tag, " mem_addr"},       32'(mem_addr),       32'(maddr));
      checkOutput({tag, " mem_data_in"},    32'(mem_data_in),    32'(mdin));
      checkOutput({tag, " fill_data"},      32'(fill_data),      32'(fdata));
      checkOutput({tag, " fill_addr"},      32'(fill_addr),      32'(faddr));
      checkOutput({tag, " icache_data_we"}, 32'(icache_data_we), 32'(idwe));
      checkOutput({tag, " dcache_data_we"}, 32'(dcache_data_we), 32'(ddwe));
      checkOutput({tag, " icache_tag_we"},  32'(icache_tag_we),  32'(itwe));
      checkOutput({tag, " dcache_tag_we"},  32'(dcache_tag_we),  32'(dtwe));
      checkOutput({tag, " if_stall"},       32'(if_stall),       32'(ifs));
      checkOutput({tag, " mem_stall"},      32'(mem_stall),      32'(ms));
   endtask

   task automatic checkIdle(input string tag, input logic ifs, input logic ms);
      checkCycle(tag, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ifs, ms);
   endtask

   // Expected outputs k cycles into a fill: reads in k=0..WPB-1, words in k=LAT..LAT+WPB-1.
   task automatic checkFillCycle(input string tag, input logic is_d, input logic [AW-1:0] base,
                                 input int k, input logic ifs, input logic ms);
      logic          en;
      logic          we;
      logic          twe;
      logic [AW-1:0] maddr;
      logic [AW-1:0] faddr;
      logic [DW-1:0] fdata;
      en    = (k < WPB);
      maddr = en ? base + AW'(2 * k) : '0;
      we    = (k >= LAT) && (k < LAT + WPB);
      faddr = we ? base + AW'(2 * (k - LAT)) : '0;
      fdata = we ? (faddr ^ 16'h5A5A) : '0;
      twe   = (k == LAT + WPB - 1);
      checkCycle($sformatf("%s k=%0d", tag, k), en, 1'b0, maddr, '0, fdata, faddr,
                 we & ~is_d, we & is_d, twe & ~is_d, twe & is_d, ifs, ms);
   endtask

   initial begin
      rst              = 1'b1;
      icache_miss      = 1'b0;
      icache_miss_addr = '0;
      dcache_miss      = 1'b0;
      dcache_miss_addr = '0;
      dcache_wr_req    = 1'b0;
      dcache_wr_addr   = '0;
      dcache_wr_data   = '0;

      // Reset held two cycles, then released with no requests.
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("reset c1", 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("reset c2", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("post reset", 1'b0, 1'b0);

      // I-cache miss at 0x1236 fills block 0x1230.
      applyStimulus(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("imiss latch", 1'b1, 1'b0);
      for (int k = 0; k < LAT + WPB; k++) begin
         applyStimulus(1'b0, 1'b1, 16'h1236, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkFillCycle("imiss", 1'b0, 16'h1230, k, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("imiss done", 1'b0, 1'b0);

      // Simultaneous I (0x0040) and D (0x8008) misses: D block first, one idle cycle, then I.
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1, 16'h8008, 1'b0, 16'h0, 16'h0);
      checkIdle("dual latch", 1'b1, 1'b1);
      for (int k = 0; k < LAT + WPB; k++) begin
         applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkFillCycle("dual dfill", 1'b1, 16'h8000, k, 1'b1, 1'b1);
      end
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("dual gap", 1'b1, 1'b0);
      for (int k = 0; k < LAT + WPB; k++) begin
         applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkFillCycle("dual ifill", 1'b0, 16'h0040, k, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("dual done", 1'b0, 1'b0);

      // Store in IDLE beats a pending I miss, which then starts a cycle later.
      applyStimulus(1'b0, 1'b1, 16'h0106, 1'b0, 16'h0, 1'b1, 16'h2002, 16'hBEEF);
      checkCycle("store idle", 1'b1, 1'b1, 16'h2002, 16'hBEEF, '0, '0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0106, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("store imiss latch", 1'b1, 1'b0);

      // Store arriving during the I fill stalls MEM and goes out in the first IDLE cycle.
      for (int k = 0; k < LAT + WPB; k++) begin
         applyStimulus(1'b0, 1'b1, 16'h0106, 1'b0, 16'h0, (k >= 2), 16'h3004, 16'h1234);
         checkFillCycle("store in fill", 1'b0, 16'h0100, k, 1'b1, (k >= 2));
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h3004, 16'h1234);
      checkCycle("deferred store", 1'b1, 1'b1, 16'h3004, 16'h1234, '0, '0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("store done", 1'b0, 1'b0);

      // Reset alongside the third returned word aborts the fill; late words are dropped.
      applyStimulus(1'b0, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("abort latch", 1'b1, 1'b0);
      for (int k = 0; k <= LAT + 2; k++) begin
         applyStimulus((k == LAT + 2), 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkFillCycle("abort fill", 1'b0, 16'h4440, k, 1'b1, 1'b0);
      end
      for (int k = LAT + 3; k < LAT + WPB + 1; k++) begin
         applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkIdle($sformatf("after abort k=%0d", k), 1'b0, 1'b0);
      end

      // Re-issued miss starts over from the first word of the block.
      applyStimulus(1'b0, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("refill latch", 1'b1, 1'b0);
      for (int k = 0; k < LAT + WPB; k++) begin
         applyStimulus(1'b0, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
         checkFillCycle("refill", 1'b0, 16'h4440, k, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
      checkIdle("refill done", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
